// File: rtl/ex_result_buf_if.sv
// ex_result_buf_if -- signal bundle between the EX stage, the EX/MEM result
// buffer and the MEM stage.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1. A producer holding valid keeps its payload
// stable until that edge. Ready never depends combinationally on the same
// side's valid.
//
// Signals
//   EX side   : ex_valid, ex_ready, ex_pc, ex_inst, inst_shift, inst_word,
//               alu_res, shifter_res, rd_wen, rd_addr, ex_mem_ren,
//               ex_mem_wen, rs2_data
//   control   : flush
//   MEM side  : mem_valid, mem_ready, mem_pc, mem_inst, mem_res, mem_rd_wen,
//               mem_rd_addr, mem_ren, mem_wen, mem_wdata
//   status    : rd_pending (register-pending scoreboard), stall_cnt
//
// The EX-side memory read/write enables carry an ex_ prefix because the MEM
// side presents signals of the same name.
//
// Modports
//   master : the pipeline around the buffer (drives EX inputs, mem_ready)
//   slave  : the buffer itself
interface ex_result_buf_if #(
    parameter int CNT_W = 32
);
    logic             ex_valid;
    logic             ex_ready;
    logic [63:0]      ex_pc;
    logic [31:0]      ex_inst;
    logic             inst_shift;
    logic             inst_word;
    logic [63:0]      alu_res;
    logic [63:0]      shifter_res;
    logic             rd_wen;
    logic [4:0]       rd_addr;
    logic             ex_mem_ren;
    logic             ex_mem_wen;
    logic [63:0]      rs2_data;
    logic             flush;

    logic             mem_valid;
    logic             mem_ready;
    logic [63:0]      mem_pc;
    logic [31:0]      mem_inst;
    logic [63:0]      mem_res;
    logic             mem_rd_wen;
    logic [4:0]       mem_rd_addr;
    logic             mem_ren;
    logic             mem_wen;
    logic [63:0]      mem_wdata;

    logic [31:0]      rd_pending;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output ex_valid, ex_pc, ex_inst, inst_shift, inst_word, alu_res,
               shifter_res, rd_wen, rd_addr, ex_mem_ren, ex_mem_wen,
               rs2_data, flush, mem_ready,
        input  ex_ready, mem_valid, mem_pc, mem_inst, mem_res, mem_rd_wen,
               mem_rd_addr, mem_ren, mem_wen, mem_wdata, rd_pending,
               stall_cnt
    );

    modport slave (
        input  ex_valid, ex_pc, ex_inst, inst_shift, inst_word, alu_res,
               shifter_res, rd_wen, rd_addr, ex_mem_ren, ex_mem_wen,
               rs2_data, flush, mem_ready,
        output ex_ready, mem_valid, mem_pc, mem_inst, mem_res, mem_rd_wen,
               mem_rd_addr, mem_ren, mem_wen, mem_wdata, rd_pending,
               stall_cnt
    );
endinterface

// File: rtl/ex_result_buf.sv
// ex_result_buf -- 2-entry EX/MEM result buffer.
//
// Selects the EX result (shifter or ALU, sign-extended from bit 31 for RV64
// *W operations), queues it with the rest of the instruction context in a
// 2-entry FIFO and presents the head to the MEM stage. Also provides a
// register-pending scoreboard over the buffered entries and a saturating
// count of cycles the EX stage was back-pressured.
//
// Ports
//   clk  : sole clock, rising edge
//   rst  : synchronous, active-high reset (overrides flush/push/pop)
//   bus  : ex_result_buf_if.slave -- EX inputs, MEM outputs, flush, status
//
// ex_ready is derived from occupancy only, so there is no combinational
// path from mem_ready to ex_ready. A full buffer accepts again one cycle
// after a pop.
module ex_result_buf #(
    parameter int CNT_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    ex_result_buf_if.slave bus
);

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [63:0] res;
        logic        rd_wen;
        logic [4:0]  rd_addr;
        logic        mem_ren;
        logic        mem_wen;
        logic [63:0] wdata;
    } entry_t;

    entry_t           entry_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [CNT_W-1:0] stall_q;

    logic             push;
    logic             pop;
    logic             ex_ready;
    logic             mem_valid;
    logic [63:0]      sel_res;
    entry_t           new_entry;
    entry_t           head;
    logic [1:0]       entry_valid;
    logic [31:0]      pending;

    assign ex_ready  = (count_q != 2'd2);
    assign mem_valid = (count_q != 2'd0);
    // A flushed cycle never pushes; a pop in that cycle still completes.
    assign push      = bus.ex_valid & ex_ready & ~bus.flush;
    assign pop       = mem_valid & bus.mem_ready;

    always_comb begin
        sel_res = bus.inst_shift ? bus.shifter_res : bus.alu_res;
        if (bus.inst_word) begin
            sel_res[63:32] = {32{sel_res[31]}};
        end
    end

    always_comb begin
        new_entry         = '0;
        new_entry.pc      = bus.ex_pc;
        new_entry.inst    = bus.ex_inst;
        new_entry.res     = sel_res;
        new_entry.rd_wen  = bus.rd_wen;
        new_entry.rd_addr = bus.rd_addr;
        new_entry.mem_ren = bus.ex_mem_ren;
        new_entry.mem_wen = bus.ex_mem_wen;
        new_entry.wdata   = bus.rs2_data;
    end

    // Slot e holds a live entry when full, or when it is the head of a
    // single-entry buffer.
    always_comb begin
        entry_valid[0] = (count_q == 2'd2) || ((count_q == 2'd1) && (rd_ptr_q == 1'b0));
        entry_valid[1] = (count_q == 2'd2) || ((count_q == 2'd1) && (rd_ptr_q == 1'b1));
    end

    always_comb begin
        pending = '0;
        for (int e = 0; e < 2; e++) begin
            if (entry_valid[e] && entry_q[e].rd_wen) begin
                pending[entry_q[e].rd_addr] = 1'b1;
            end
        end
        // x0 is hardwired to zero and is never a hazard.
        pending[0] = 1'b0;
    end

    always_comb begin
        head = '0;
        if (mem_valid) begin
            head = entry_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else if (bus.flush) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            if (push) begin
                entry_q[wr_ptr_q] <= new_entry;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Counts independently of flush; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (bus.ex_valid && !ex_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign bus.ex_ready    = ex_ready;
    assign bus.mem_valid   = mem_valid;
    assign bus.mem_pc      = head.pc;
    assign bus.mem_inst    = head.inst;
    assign bus.mem_res     = head.res;
    assign bus.mem_rd_wen  = head.rd_wen;
    assign bus.mem_rd_addr = head.rd_addr;
    assign bus.mem_ren     = head.mem_ren;
    assign bus.mem_wen     = head.mem_wen;
    assign bus.mem_wdata   = head.wdata;
    assign bus.rd_pending  = pending;
    assign bus.stall_cnt   = stall_q;

endmodule

// File: tb/tb_ex_result_buf.sv
// tb_ex_result_buf -- directed, scoreboard-checked bench for ex_result_buf.
// Inputs change on the falling edge; the monitor samples 2 time units after
// the falling edge and pops the expected queue on every MEM-side transfer.
module tb_ex_result_buf;
    localparam int CNT_W = 32;
    localparam int EW    = 232;

    logic clk;
    logic rst;

    ex_result_buf_if #(.CNT_W(CNT_W)) bus ();

    ex_result_buf #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;
    int n_pop  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (!rst && bus.mem_valid && bus.mem_ready) begin
            logic [EW-1:0] act;
            act = {bus.mem_pc, bus.mem_inst, bus.mem_res, bus.mem_rd_wen,
                   bus.mem_rd_addr, bus.mem_ren, bus.mem_wen, bus.mem_wdata};
            n_cmp++;
            n_pop++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL mem_entry: got unexpected output %h required none", act);
            end else begin
                logic [EW-1:0] exp;
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL mem_entry: got %h required %h", act, exp);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_ex(input logic [63:0] pc, input logic [31:0] inst,
                            input logic shift, input logic word,
                            input logic [63:0] alu, input logic [63:0] sh,
                            input logic rdw, input logic [4:0] rda,
                            input logic mr, input logic mw, input logic [63:0] rs2);
        bus.ex_valid    = 1'b1;
        bus.ex_pc       = pc;
        bus.ex_inst     = inst;
        bus.inst_shift  = shift;
        bus.inst_word   = word;
        bus.alu_res     = alu;
        bus.shifter_res = sh;
        bus.rd_wen      = rdw;
        bus.rd_addr     = rda;
        bus.ex_mem_ren  = mr;
        bus.ex_mem_wen  = mw;
        bus.rs2_data    = rs2;
    endtask

    // Called on a falling edge; returns on the falling edge after the push.
    task automatic send(input logic [63:0] pc, input logic [31:0] inst,
                        input logic shift, input logic word,
                        input logic [63:0] alu, input logic [63:0] sh,
                        input logic [63:0] exp_res,
                        input logic rdw, input logic [4:0] rda,
                        input logic mr, input logic mw, input logic [63:0] rs2);
        bit done;
        done = 1'b0;
        drive_ex(pc, inst, shift, word, alu, sh, rdw, rda, mr, mw, rs2);
        for (int t = 0; t < 20 && !done; t++) begin
            #1;
            if (bus.ex_ready) begin
                exp_q.push_back({pc, inst, exp_res, rdw, rda, mr, mw, rs2});
                done = 1'b1;
            end
            @(negedge clk);
        end
        bus.ex_valid = 1'b0;
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: got ex_ready=0 for 20 cycles required acceptance, pc %h", pc);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_mem_valid"}, 64'(bus.mem_valid), 64'd0);
        check({tag, "_payload_zero"},
              64'(({bus.mem_pc, bus.mem_inst, bus.mem_res, bus.mem_rd_wen, bus.mem_rd_addr,
                    bus.mem_ren, bus.mem_wen, bus.mem_wdata} == '0) ? 1 : 0), 64'd1);
        check({tag, "_rd_pending"}, 64'(bus.rd_pending), 64'd0);
        check({tag, "_ex_ready"}, 64'(bus.ex_ready), 64'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [CNT_W-1:0] s0;
        int p0;

        rst = 1'b1;
        bus.ex_valid = 1'b0; bus.ex_pc = '0; bus.ex_inst = '0; bus.inst_shift = 1'b0;
        bus.inst_word = 1'b0; bus.alu_res = '0; bus.shifter_res = '0; bus.rd_wen = 1'b0;
        bus.rd_addr = '0; bus.ex_mem_ren = 1'b0; bus.ex_mem_wen = 1'b0; bus.rs2_data = '0;
        bus.flush = 1'b0; bus.mem_ready = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle("reset");
        check("reset_stall_cnt", 64'(bus.stall_cnt), 64'd0);
        @(negedge clk);

        // *W shifter result sign-extends, one-cycle latency
        bus.mem_ready = 1'b1;
        send(64'h0000_0000_0000_1000, 32'h0010_009b, 1'b1, 1'b1, 64'h0000_0000_0000_1234,
             64'h0000_0000_8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b1, 5'd3, 1'b0, 1'b0, 64'h0);
        #1;
        check("w_shift_mem_valid", 64'(bus.mem_valid), 64'd1);
        check("w_shift_mem_res", bus.mem_res, 64'hFFFF_FFFF_8000_0000);
        @(negedge clk);
        // full-width ALU result passes unchanged
        send(64'h0000_0000_0000_1004, 32'h00b5_0533, 1'b0, 1'b0, 64'h1234_5678_9abc_def0,
             64'hdead_beef_0000_0000, 64'h1234_5678_9abc_def0, 1'b1, 5'd10, 1'b0, 1'b1,
             64'h0102_0304_0506_0708);
        // *W ALU result with bit31=0 zero-fills the upper half
        send(64'h0000_0000_0000_1008, 32'h0000_003b, 1'b0, 1'b1, 64'hFFFF_FFFF_7FFF_FFFF,
             64'h0, 64'h0000_0000_7FFF_FFFF, 1'b0, 5'd12, 1'b1, 1'b0, 64'h0);
        repeat (3) @(negedge clk);

        // back-pressure: two fill, third waits
        bus.mem_ready = 1'b0;
        s0 = bus.stall_cnt;
        send(64'h2000, 32'h0000_0293, 1'b0, 1'b0, 64'h55, 64'h0, 64'h55, 1'b1, 5'd5, 1'b0, 1'b0, 64'h0);
        send(64'h2004, 32'h0000_0393, 1'b0, 1'b0, 64'h77, 64'h0, 64'h77, 1'b1, 5'd7, 1'b0, 1'b0, 64'h0);
        #1;
        check("full_ex_ready", 64'(bus.ex_ready), 64'd0);
        check("full_rd_pending", 64'(bus.rd_pending), 64'h0000_00A0);
        fork
            send(64'h2008, 32'h0000_0493, 1'b0, 1'b0, 64'h99, 64'h0, 64'h99, 1'b1, 5'd9, 1'b0, 1'b0, 64'h0);
            begin
                repeat (3) @(negedge clk);
                #1;
                check("stall_3_cycles", 64'(bus.stall_cnt), 64'(s0 + 3));
                bus.mem_ready = 1'b1;
            end
        join
        check("stall_after_release", 64'(bus.stall_cnt), 64'(s0 + 4));
        repeat (3) @(negedge clk);
        #1;
        check("drained_rd_pending", 64'(bus.rd_pending), 64'd0);
        @(negedge clk);

        // flush while full, with a same-cycle instruction
        bus.mem_ready = 1'b0;
        send(64'h3000, 32'h0000_0593, 1'b0, 1'b0, 64'h11, 64'h0, 64'h11, 1'b1, 5'd11, 1'b0, 1'b0, 64'h0);
        send(64'h3004, 32'h0000_0693, 1'b0, 1'b0, 64'h13, 64'h0, 64'h13, 1'b1, 5'd13, 1'b0, 1'b0, 64'h0);
        s0 = bus.stall_cnt;
        p0 = n_pop;
        drive_ex(64'h3008, 32'h0000_0793, 1'b0, 1'b0, 64'h15, 64'h0, 1'b1, 5'd15, 1'b0, 1'b0, 64'h0);
        bus.flush = 1'b1;
        exp_q.delete();
        @(negedge clk);
        bus.flush = 1'b0;
        bus.ex_valid = 1'b0;
        #1;
        check("flush_mem_valid", 64'(bus.mem_valid), 64'd0);
        check("flush_rd_pending", 64'(bus.rd_pending), 64'd0);
        check("flush_ex_ready", 64'(bus.ex_ready), 64'd1);
        check("flush_keeps_stall", 64'(bus.stall_cnt), 64'(s0 + 1));
        @(negedge clk);
        bus.mem_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("flush_no_output", 64'(n_pop - p0), 64'd0);

        // stream 100 back-to-back with mem_ready=1
        s0 = bus.stall_cnt;
        p0 = n_pop;
        for (int i = 0; i < 100; i++) begin
            logic [63:0] a;
            logic [63:0] s;
            a = 64'h0000_1000_0000_0000 + 64'(i);
            s = 64'h0000_2000_0000_0000 + 64'(i * 3);
            send(64'h4000 + 64'(i * 4), 32'h0000_0013 + 32'(i), i[0], 1'b0, a, s,
                 i[0] ? s : a, 1'b1, 5'(i), i[1], i[2], 64'(i * 7));
        end
        #3;
        check("stream_outputs", 64'(n_pop - p0), 64'd100);
        check("stream_no_stall", 64'(bus.stall_cnt), 64'(s0));
        @(negedge clk);

        // rd_addr 0 never marked pending
        bus.mem_ready = 1'b0;
        send(64'h5000, 32'h0000_0013, 1'b0, 1'b0, 64'h42, 64'h0, 64'h42, 1'b1, 5'd0, 1'b0, 1'b0, 64'h0);
        #1;
        check("x0_mem_valid", 64'(bus.mem_valid), 64'd1);
        check("x0_mem_rd_addr", 64'(bus.mem_rd_addr), 64'd0);
        check("x0_mem_rd_wen", 64'(bus.mem_rd_wen), 64'd1);
        check("x0_rd_pending", 64'(bus.rd_pending), 64'd0);
        @(negedge clk);
        bus.mem_ready = 1'b1;
        repeat (3) @(negedge clk);

        // reset mid-stream: full buffer, stall_cnt = 9
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.mem_ready = 1'b0;
        send(64'h6000, 32'h0000_0a93, 1'b0, 1'b0, 64'h21, 64'h0, 64'h21, 1'b1, 5'd21, 1'b0, 1'b0, 64'h0);
        send(64'h6004, 32'h0000_0b13, 1'b0, 1'b0, 64'h22, 64'h0, 64'h22, 1'b1, 5'd22, 1'b1, 1'b0, 64'h0);
        drive_ex(64'h6008, 32'h0000_0b93, 1'b0, 1'b0, 64'h23, 64'h0, 1'b1, 5'd23, 1'b0, 1'b0, 64'h0);
        repeat (9) @(negedge clk);
        #1;
        check("pre_rst_stall_cnt", 64'(bus.stall_cnt), 64'd9);
        check("pre_rst_pending", 64'(bus.rd_pending), 64'h0060_0000);
        rst = 1'b1;
        bus.flush = 1'b1;
        bus.mem_ready = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        bus.flush = 1'b0;
        bus.ex_valid = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        check_idle("mid_rst");
        check("mid_rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
        repeat (2) @(negedge clk);

        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
